coin_acceptor: RTL

Front-end stage that feeds the vending FSM's coin[1:0] input. It synchronises and debounces the two raw coin-sensor lines from the mechanical acceptor, and issues exactly one single-cycle coin code per physical insertion. It also flags invalid insertions (reject pulse) and stuck sensors (jam level).

---
 rtl/vend_pkg.sv | 24 ++
 rtl/coin_acceptor_if.sv | 20 ++
 rtl/coin_debounce.sv | 51 +++++
 rtl/coin_acceptor.sv | 103 ++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Brief    : Shared coin-code constants and coin_acceptor state encoding,
//             common to the coin acceptor and the vending FSM.
//  Revision : 1.0  initial release
// ============================================================================
package vend_pkg;

    // Coin codes presented to the vending FSM
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;

    // Coin acceptor control states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_JAM      = 2'd3
    } acc_state_t;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor_if
//  Brief    : Sensor inputs and coin/reject/jam outputs of the coin acceptor.
//             master = sensor side / observer, slave = coin_acceptor.
//  Revision : 1.0  initial release
// ============================================================================
interface coin_acceptor_if;
    logic       sns_one;
    logic       sns_two;
    logic [1:0] coin;
    logic       reject;
    logic       jam;

    modport master (output sns_one, output sns_two,
                    input  coin,    input  reject, input jam);
    modport slave  (input  sns_one, input  sns_two,
                    output coin,    output reject, output jam);
endinterface : coin_acceptor_if
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : coin_debounce
//  Brief    : Two-flop synchroniser followed by a stable-level counter. The
//             debounced level follows the synchronised level only once it has
//             differed for DEB_CYCLES consecutive cycles.
//  Revision : 1.0  initial release
// ============================================================================
module coin_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic sns,
    output logic      deb
);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    // Synchronise the raw sensor, then accept a new level after a stable run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else begin
            r_s1 <= sns;
            r_s2 <= r_s1;
            if (r_s2 != r_deb) begin
                // Last differing cycle of the run: commit the new level
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign deb = r_deb;

endmodule : coin_debounce
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor
//  Brief    : Debounces the two coin sensors and issues one single-cycle coin
//             code per insertion; flags invalid insertions (reject) and stuck
//             sensors (jam).
//  Revision : 1.0  initial release
// ============================================================================
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 1000,
    parameter int CNT_W      = 10
) (
    input  wire logic       clk,
    input  wire logic       rst,
    coin_acceptor_if.slave  bus
);

    logic             w_deb_one;
    logic             w_deb_two;
    logic             w_any;
    acc_state_t       r_state;
    logic [CNT_W-1:0] r_jcnt;
    logic [1:0]       r_coin;
    logic             r_reject;
    logic             r_jam;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_one (
        .clk (clk),
        .rst (rst),
        .sns (bus.sns_one),
        .deb (w_deb_one)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_two (
        .clk (clk),
        .rst (rst),
        .sns (bus.sns_two),
        .deb (w_deb_two)
    );

    assign w_any = w_deb_one | w_deb_two;

    // Insertion control: one coin or reject per insertion, jam on stuck sensor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_jcnt   <= '0;
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            r_jam    <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_jcnt <= '0;
                    // Any high debounced level in IDLE is a fresh insertion
                    if (w_deb_one && w_deb_two) begin
                        r_reject <= 1'b1;
                        r_state  <= ST_WAIT_REL;
                    end else if (w_deb_one) begin
                        r_coin  <= COIN_ONE;
                        r_state <= ST_ISSUE;
                    end else if (w_deb_two) begin
                        r_coin  <= COIN_TWO;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT_REL: begin
                    if (w_any) begin
                        if (r_jcnt == CNT_W'(JAM_CYCLES - 1)) begin
                            r_jam   <= 1'b1;
                            r_state <= ST_JAM;
                        end else begin
                            r_jcnt  <= r_jcnt + CNT_W'(1);
                            r_state <= ST_WAIT_REL;
                        end
                    end else begin
                        // ISSUE always spends one cycle before release check
                        r_state <= (r_state == ST_ISSUE) ? ST_WAIT_REL : ST_IDLE;
                    end
                end
                ST_JAM: begin
                    if (!w_any) begin
                        r_jam   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.coin   = r_coin;
    assign bus.reject = r_reject;
    assign bus.jam    = r_jam;

endmodule : coin_acceptor
`default_nettype wire
